// File: rtl/edram_pkg.sv
// Shared types and helpers for the eDRAM bank sequencer: FSM state encoding,
// post-precharge goal, default geometry and the word-address split.
package edram_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PRE,
        ST_ACT,
        ST_SENSE,
        ST_ACCESS,
        ST_REFRESH,
        ST_SLEEP
    } state_t;

    // Where a precharge hands control once the row is closed
    typedef enum logic [1:0] {
        GOAL_ACT,
        GOAL_REF,
        GOAL_SLEEP
    } pre_goal_t;

    localparam int DEF_ROWS          = 256;
    localparam int DEF_WORDS_PER_ROW = 8;
    localparam int DEF_ADDR_W        = $clog2(DEF_ROWS * DEF_WORDS_PER_ROW);
    localparam int TMR_W             = 16;

    typedef struct packed {
        logic [31:0] row;
        logic [31:0] col;
    } addr_split_t;

    function automatic addr_split_t split_addr(input logic [31:0] addr, input int col_w);
        addr_split_t s;
        s.col = addr & ((32'd1 << col_w) - 32'd1);
        s.row = addr >> col_w;
        return s;
    endfunction

endpackage

// File: rtl/edram_row_array.sv
// Storage array plus the single open-row buffer; whole rows move between them,
// words are read from and byte-merged into the buffer.
module edram_row_array #(
    parameter int DATA_W        = 32,
    parameter int ROWS          = 256,
    parameter int WORDS_PER_ROW = 8,
    localparam int ROW_W        = $clog2(ROWS),
    localparam int COL_W        = $clog2(WORDS_PER_ROW),
    localparam int BE_W         = DATA_W / 8
) (
    input  logic              clk,
    input  logic              load_row,
    input  logic              writeback_row,
    input  logic [ROW_W-1:0]  row_sel,
    input  logic              write_word,
    input  logic [COL_W-1:0]  col_sel,
    input  logic [DATA_W-1:0] wdata,
    input  logic [BE_W-1:0]   be,
    output logic [DATA_W-1:0] read_word
);
    localparam int ROW_BITS = DATA_W * WORDS_PER_ROW;
    localparam int NBYTES   = ROW_BITS / 8;

    logic [ROW_BITS-1:0] mem [ROWS];
    logic [ROW_BITS-1:0] row_buf_q;
    logic [ROW_BITS-1:0] row_buf_d;

    genvar gi;
    generate
        for (gi = 0; gi < NBYTES; gi++) begin : g_byte
            localparam int WI = gi / BE_W;
            localparam int BI = gi % BE_W;
            assign row_buf_d[gi*8 +: 8] =
                (write_word && (col_sel == COL_W'(WI)) && be[BI]) ? wdata[BI*8 +: 8]
                                                                  : row_buf_q[gi*8 +: 8];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (writeback_row) begin
            mem[row_sel] <= row_buf_q;
        end
        if (load_row) begin
            row_buf_q <= mem[row_sel];
        end else begin
            row_buf_q <= row_buf_d;
        end
    end

    assign read_word = row_buf_q[col_sel*DATA_W +: DATA_W];

endmodule

// File: rtl/edram_bank_seq.sv
// eDRAM bank sequencer: request handshake, precharge/activate/sense/access timing,
// open-row reuse, distributed refresh and self-refresh sleep.
module edram_bank_seq
    import edram_pkg::*;
#(
    parameter int DATA_W        = 32,
    parameter int ROWS          = DEF_ROWS,
    parameter int WORDS_PER_ROW = DEF_WORDS_PER_ROW,
    parameter int T_PRE         = 2,
    parameter int T_ACT         = 2,
    parameter int T_SENSE       = 1,
    parameter int REF_INTERVAL  = 64,
    localparam int ADDR_W       = $clog2(ROWS * WORDS_PER_ROW)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [ADDR_W-1:0]     req_addr,
    input  logic [DATA_W-1:0]     req_wdata,
    input  logic [DATA_W/8-1:0]   req_be,
    output logic                  rsp_valid,
    output logic [DATA_W-1:0]     rsp_rdata,
    input  logic                  sleep_req,
    output logic                  sleep_ack,
    output logic                  ref_busy,
    output logic                  ref_miss
);
    localparam int ROW_W = $clog2(ROWS);
    localparam int COL_W = $clog2(WORDS_PER_ROW);
    localparam int BE_W  = DATA_W / 8;
    localparam int REF_W = $clog2(REF_INTERVAL);

    state_t              state_q, state_d;
    pre_goal_t           pre_goal_q, pre_goal_d;
    logic                ret_sleep_q, ret_sleep_d;
    logic [TMR_W-1:0]    timer_q, timer_d;
    logic                row_open_q, row_open_d;
    logic [ROW_W-1:0]    open_row_q, open_row_d;
    logic [ROW_W-1:0]    tgt_row_q, tgt_row_d;
    logic [ROW_W-1:0]    ref_row_q, ref_row_d;
    logic [COL_W-1:0]    col_q, col_d;
    logic                we_q, we_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [BE_W-1:0]     be_q, be_d;
    logic [REF_W-1:0]    ref_cnt_q, ref_cnt_d;
    logic                pending_q, pending_d;
    logic                miss_q, miss_d;
    logic                rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0]   rsp_rdata_q, rsp_rdata_d;

    addr_split_t         req_split;
    logic [ROW_W-1:0]    req_row;
    logic [COL_W-1:0]    req_col;
    logic                unused_split;
    logic                accept, tdone, row_hit, ref_done;
    logic [DATA_W-1:0]   rd_word;

    function automatic logic [TMR_W-1:0] state_cycles(input state_t s);
        case (s)
            ST_PRE:     return TMR_W'(T_PRE - 1);
            ST_ACT:     return TMR_W'(T_ACT - 1);
            ST_SENSE:   return TMR_W'(T_SENSE - 1);
            ST_REFRESH: return TMR_W'(T_ACT + T_SENSE - 1);
            default:    return '0;
        endcase
    endfunction

    assign req_split    = split_addr(32'(req_addr), COL_W);
    assign req_row      = req_split.row[ROW_W-1:0];
    assign req_col      = req_split.col[COL_W-1:0];
    assign unused_split = ^{req_split.row[31:ROW_W], req_split.col[31:COL_W]};

    assign accept   = req_valid && req_ready;
    assign tdone    = (timer_q == '0);
    assign row_hit  = row_open_q && (open_row_q == req_row);
    assign ref_done = (state_q == ST_REFRESH) && tdone;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        pre_goal_d  = pre_goal_q;
        ret_sleep_d = ret_sleep_q;
        case (state_q)
            ST_IDLE: begin
                if (pending_q) begin
                    ret_sleep_d = 1'b0;
                    if (row_open_q) begin
                        state_d    = ST_PRE;
                        pre_goal_d = GOAL_REF;
                    end else begin
                        state_d = ST_REFRESH;
                    end
                end else if (sleep_req) begin
                    if (row_open_q) begin
                        state_d    = ST_PRE;
                        pre_goal_d = GOAL_SLEEP;
                    end else begin
                        state_d = ST_SLEEP;
                    end
                end else if (accept) begin
                    if (row_hit) begin
                        state_d = ST_ACCESS;
                    end else if (row_open_q) begin
                        state_d    = ST_PRE;
                        pre_goal_d = GOAL_ACT;
                    end else begin
                        state_d = ST_ACT;
                    end
                end
            end
            ST_PRE: begin
                if (tdone) begin
                    case (pre_goal_q)
                        GOAL_REF:   state_d = ST_REFRESH;
                        GOAL_SLEEP: state_d = ST_SLEEP;
                        default:    state_d = ST_ACT;
                    endcase
                end
            end
            ST_ACT:     if (tdone) state_d = ST_SENSE;
            ST_SENSE:   if (tdone) state_d = ST_ACCESS;
            ST_ACCESS:  state_d = ST_IDLE;
            ST_REFRESH: if (tdone) state_d = ret_sleep_q ? ST_SLEEP : ST_IDLE;
            ST_SLEEP: begin
                if (pending_q) begin
                    state_d     = ST_REFRESH;
                    ret_sleep_d = 1'b1;
                end else if (!sleep_req) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        timer_d     = timer_q;
        row_open_d  = row_open_q;
        open_row_d  = open_row_q;
        tgt_row_d   = tgt_row_q;
        col_d       = col_q;
        we_d        = we_q;
        wdata_d     = wdata_q;
        be_d        = be_q;
        ref_row_d   = ref_row_q;
        ref_cnt_d   = ref_cnt_q - REF_W'(1);
        pending_d   = pending_q;
        miss_d      = miss_q;
        rsp_valid_d = (state_q == ST_ACCESS);
        rsp_rdata_d = rsp_rdata_q;

        if (state_d != state_q) begin
            timer_d = state_cycles(state_d);
        end else if (timer_q != '0) begin
            timer_d = timer_q - TMR_W'(1);
        end

        if (accept) begin
            tgt_row_d = req_row;
            col_d     = req_col;
            we_d      = req_we;
            wdata_d   = req_wdata;
            be_d      = req_be;
        end
        if (state_q == ST_PRE && tdone) begin
            row_open_d = 1'b0;
        end
        if (state_q == ST_ACT && tdone) begin
            row_open_d = 1'b1;
            open_row_d = tgt_row_q;
        end
        if (state_q == ST_ACCESS && !we_q) begin
            rsp_rdata_d = rd_word;
        end

        if (ref_done) begin
            pending_d = 1'b0;
            ref_row_d = ref_row_q + ROW_W'(1);
        end
        // An expiry landing on the completing refresh is a fresh request, not a miss
        if (ref_cnt_q == '0) begin
            ref_cnt_d = REF_W'(REF_INTERVAL - 1);
            if (pending_q && !ref_done) begin
                miss_d = 1'b1;
            end
            pending_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pre_goal_q  <= GOAL_ACT;
            ret_sleep_q <= 1'b0;
            timer_q     <= '0;
            row_open_q  <= 1'b0;
            open_row_q  <= '0;
            tgt_row_q   <= '0;
            col_q       <= '0;
            we_q        <= 1'b0;
            wdata_q     <= '0;
            be_q        <= '0;
            ref_row_q   <= '0;
            ref_cnt_q   <= REF_W'(REF_INTERVAL - 1);
            pending_q   <= 1'b0;
            miss_q      <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
        end else begin
            pre_goal_q  <= pre_goal_d;
            ret_sleep_q <= ret_sleep_d;
            timer_q     <= timer_d;
            row_open_q  <= row_open_d;
            open_row_q  <= open_row_d;
            tgt_row_q   <= tgt_row_d;
            col_q       <= col_d;
            we_q        <= we_d;
            wdata_q     <= wdata_d;
            be_q        <= be_d;
            ref_row_q   <= ref_row_d;
            ref_cnt_q   <= ref_cnt_d;
            pending_q   <= pending_d;
            miss_q      <= miss_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
        end
    end

    // Refreshes issued from sleep keep sleep_ack asserted
    always_comb begin
        req_ready = (state_q == ST_IDLE) && !pending_q && !sleep_req;
        sleep_ack = (state_q == ST_SLEEP) || ((state_q == ST_REFRESH) && ret_sleep_q);
        ref_busy  = (state_q == ST_REFRESH);
        ref_miss  = miss_q;
        rsp_valid = rsp_valid_q;
        rsp_rdata = rsp_rdata_q;
    end

    edram_row_array #(
        .DATA_W        (DATA_W),
        .ROWS          (ROWS),
        .WORDS_PER_ROW (WORDS_PER_ROW)
    ) u_array (
        .clk           (clk),
        .load_row      (state_q == ST_ACT),
        .writeback_row (state_q == ST_PRE),
        .row_sel       ((state_q == ST_PRE) ? open_row_q : tgt_row_q),
        .write_word    ((state_q == ST_ACCESS) && we_q),
        .col_sel       (col_q),
        .wdata         (wdata_q),
        .be            (be_q),
        .read_word     (rd_word)
    );

endmodule
